// File: rtl/rsa_arb_pkg.sv
// rtl/rsa_arb_pkg.sv - shared types and defaults for the RSA job arbiter
package rsa_arb_pkg;

  localparam int DEF_BITS = 4;
  localparam int DEF_NREQ = 4;

  // Width of one requester's operand slice in the packed x/e/m buses
  localparam int SLICE_W  = DEF_BITS;

  // One-hot FSM encoding
  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_GRANT    = 5'b00010,
    S_RUN      = 5'b00100,
    S_COMPLETE = 5'b01000,
    S_GAP      = 5'b10000
  } arb_state_e;

  // Index width for a requester count, never narrower than one bit
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rsa_job_arbiter_rr_pick.sv
// rtl/rsa_job_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
  import rsa_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]           req_i,
  input  logic [id_width(NREQ)-1:0] ptr_i,
  output logic [id_width(NREQ)-1:0] idx_o,
  output logic                      valid_o
);

  localparam int IDW = id_width(NREQ);

  // Scan from the farthest offset back to ptr so the nearest set bit at or after ptr wins
  always_comb begin
    int c;
    valid_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= NREQ) c = c - NREQ;
      if (req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = c[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/rsa_job_arbiter.sv
// rtl/rsa_job_arbiter.sv - round-robin sharing of one modexp engine; watchdog under RSA_ARB_WATCHDOG_EN
module rsa_job_arbiter
  import rsa_arb_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int NREQ       = DEF_NREQ,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BITS-1:0]      x_in,
  input  logic [NREQ*BITS-1:0]      e_in,
  input  logic [NREQ*BITS-1:0]      m_in,
  output logic [NREQ-1:0]           ack,
  output logic [BITS-1:0]           res_z,
  output logic [id_width(NREQ)-1:0] res_id,
  output logic                      res_err,
  output logic                      busy,
  output logic [BITS-1:0]           eng_x,
  output logic [BITS-1:0]           eng_e,
  output logic [BITS-1:0]           eng_m,
  output logic                      eng_go,
  input  logic                      eng_done,
  input  logic [BITS-1:0]           eng_z
);

  localparam int IDW = id_width(NREQ);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  arb_state_e       state_q;
  logic [IDW-1:0]   cur_id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [GCW-1:0]   gap_cnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [BITS-1:0]  res_z_q;
  logic [IDW-1:0]   res_id_q;
  logic [BITS-1:0]  eng_x_q;
  logic [BITS-1:0]  eng_e_q;
  logic [BITS-1:0]  eng_m_q;
  logic             eng_go_q;

  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;

`ifdef RSA_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT);
  logic [WDW-1:0]   wd_cnt_q;
  logic             job_err_q;
  logic             res_err_q;
`endif

  rr_pick #(
    .NREQ    (NREQ)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Job sequencer: grant, engine handshake, result return and go-low gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cur_id_q  <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
      ack_q     <= '0;
      res_z_q   <= '0;
      res_id_q  <= '0;
      eng_x_q   <= '0;
      eng_e_q   <= '0;
      eng_m_q   <= '0;
      eng_go_q  <= 1'b0;
`ifdef RSA_ARB_WATCHDOG_EN
      wd_cnt_q  <= '0;
      job_err_q <= 1'b0;
      res_err_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            cur_id_q <= pick_idx;
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          eng_x_q  <= x_in[cur_id_q*BITS +: BITS];
          eng_e_q  <= e_in[cur_id_q*BITS +: BITS];
          eng_m_q  <= m_in[cur_id_q*BITS +: BITS];
          eng_go_q <= 1'b1;
          state_q  <= S_RUN;
`ifdef RSA_ARB_WATCHDOG_EN
          wd_cnt_q  <= '0;
          job_err_q <= 1'b0;
`endif
        end
        S_RUN: begin
          // A done arriving on the timeout cycle still counts as a good result
          if (eng_done) begin
            state_q <= S_COMPLETE;
          end
`ifdef RSA_ARB_WATCHDOG_EN
          else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
            job_err_q <= 1'b1;
            state_q   <= S_COMPLETE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
`endif
        end
        S_COMPLETE: begin
`ifdef RSA_ARB_WATCHDOG_EN
          res_z_q   <= job_err_q ? '0 : eng_z;
          res_err_q <= job_err_q;
`else
          res_z_q   <= eng_z;
`endif
          res_id_q         <= cur_id_q;
          ack_q[cur_id_q]  <= 1'b1;
          eng_go_q         <= 1'b0;
          rr_ptr_q         <= (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + 1'b1;
          gap_cnt_q        <= GCW'(GAP_CYCLES);
          state_q          <= S_GAP;
        end
        S_GAP: begin
          // The ack cycle plus GAP_CYCLES more keep the engine in reset
          if (gap_cnt_q == '0) state_q <= S_IDLE;
          else                 gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign res_z  = res_z_q;
  assign res_id = res_id_q;
  assign busy   = (state_q != S_IDLE);
  assign eng_x  = eng_x_q;
  assign eng_e  = eng_e_q;
  assign eng_m  = eng_m_q;
  assign eng_go = eng_go_q;

`ifdef RSA_ARB_WATCHDOG_EN
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// tb/tb_rsa_job_arbiter.sv - directed self-checking bench for rsa_job_arbiter
module tb_rsa_job_arbiter;

  localparam int BITS = 4;
  localparam int NREQ = 4;
  localparam int GAP  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*BITS-1:0] x_in, e_in, m_in;
  logic [NREQ-1:0]   ack;
  logic [BITS-1:0]   res_z;
  logic [1:0]        res_id;
  logic              res_err;
  logic              busy;
  logic [BITS-1:0]   eng_x, eng_e, eng_m;
  logic              eng_go;
  logic              eng_done;
  logic [BITS-1:0]   eng_z;

  logic              mdl_done;
  logic [5:0]        go_cnt;
  logic              force_done;
  logic              never_done;

  int n_checks = 0;
  int n_pass   = 0;

  rsa_job_arbiter #(
    .BITS(BITS), .NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .x_in(x_in), .e_in(e_in), .m_in(m_in),
    .ack(ack), .res_z(res_z), .res_id(res_id), .res_err(res_err), .busy(busy),
    .eng_x(eng_x), .eng_e(eng_e), .eng_m(eng_m), .eng_go(eng_go),
    .eng_done(eng_done), .eng_z(eng_z)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] modexp(input logic [3:0] x, input logic [3:0] e, input logic [3:0] m);
    int r;
    if (m == 0) return 4'd0;
    r = 1 % int'(m);
    for (int i = 0; i < int'(e); i++) r = (r * int'(x)) % int'(m);
    return r[3:0];
  endfunction

  // Behavioural engine: done 20 cycles after go rises, held until go falls
  always @(posedge clk) begin
    if (!eng_go) begin
      go_cnt   <= '0;
      mdl_done <= 1'b0;
    end else begin
      if (go_cnt != 6'd63) go_cnt <= go_cnt + 1'b1;
      if (go_cnt == 6'd19 && !never_done) mdl_done <= 1'b1;
    end
  end

  assign eng_done = mdl_done | force_done;
  assign eng_z    = modexp(eng_x, eng_e, eng_m);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [3:0] x, input logic [3:0] e, input logic [3:0] m);
    x_in[id*BITS +: BITS] = x;
    e_in[id*BITS +: BITS] = e;
    m_in[id*BITS +: BITS] = m;
  endtask

  task automatic wait_ack(input int budget, output int got_id, output int cycles);
    bit seen;
    seen = 0;
    got_id = -1;
    cycles = 0;
    while (!seen && cycles < budget) begin
      tick();
      cycles++;
      if (ack != '0) begin
        seen = 1;
        for (int k = 0; k < NREQ; k++) if (ack[k]) got_id = k;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [3:0] x, e, m;
    logic [3:0] z;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int id, cyc, low, extra;
    bit stale_ack;

    vecs[0] = '{id: 0, x: 4'd3,  e: 4'd5, m: 4'd13, z: 4'd9};
    vecs[1] = '{id: 1, x: 4'd6,  e: 4'd3, m: 4'd15, z: 4'd6};
    vecs[2] = '{id: 2, x: 4'd7,  e: 4'd0, m: 4'd13, z: 4'd1};
    vecs[3] = '{id: 3, x: 4'd5,  e: 4'd2, m: 4'd7,  z: 4'd4};
    vecs[4] = '{id: 1, x: 4'd2,  e: 4'd3, m: 4'd11, z: 4'd8};

    req = '0; x_in = '0; e_in = '0; m_in = '0;
    force_done = 1'b0; never_done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", int'(busy), 0);
    check("rst_eng_go", int'(eng_go), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_res_z", int'(res_z), 0);
    check("rst_res_id", int'(res_id), 0);
    check("rst_res_err", int'(res_err), 0);
    check("rst_eng_x", int'(eng_x), 0);
    rst_n = 1'b1;
    tick();

    // Single job latency: go two edges after req is raised, ack 22 edges after go
    set_ops(0, 4'd3, 4'd5, 4'd13);
    req = 4'b0001;
    tick();
    check("single_go_edge1", int'(eng_go), 0);
    check("single_busy", int'(busy), 1);
    tick();
    check("single_go_edge2", int'(eng_go), 1);
    check("single_eng_x", int'(eng_x), 3);
    check("single_eng_e", int'(eng_e), 5);
    check("single_eng_m", int'(eng_m), 13);
    wait_ack(60, id, cyc);
    check("single_ack_id", id, 0);
    check("single_ack_lat", cyc, 22);
    check("single_res_z", int'(res_z), 9);
    check("single_res_id", int'(res_id), 0);
    check("single_res_err", int'(res_err), 0);
    check("single_go_low_at_ack", int'(eng_go), 0);
    req = '0;
    wait_idle(20);

    // Table of isolated jobs
    foreach (vecs[i]) begin
      set_ops(vecs[i].id, vecs[i].x, vecs[i].e, vecs[i].m);
      req = 4'(1 << vecs[i].id);
      wait_ack(60, id, cyc);
      check($sformatf("vec%0d_ack_id", i), id, vecs[i].id);
      check($sformatf("vec%0d_onehot", i), $countones(ack), 1);
      check($sformatf("vec%0d_res_z", i), int'(res_z), int'(vecs[i].z));
      check($sformatf("vec%0d_res_id", i), int'(res_id), vecs[i].id);
      check($sformatf("vec%0d_res_err", i), int'(res_err), 0);
      req = '0;
      wait_idle(20);
    end

    // Contention from rr_ptr=0: requester 0 first, then 2, with GAP+3 go-low cycles
    do_reset();
    set_ops(0, 4'd2, 4'd3, 4'd11);
    set_ops(2, 4'd7, 4'd0, 4'd13);
    req = 4'b0101;
    wait_ack(60, id, cyc);
    check("cont_first_id", id, 0);
    check("cont_first_z", int'(res_z), 8);
    req = 4'b0100;
    low = 1;
    cyc = 0;
    while (!eng_go && cyc < 20) begin
      tick();
      cyc++;
      if (!eng_go) low++;
    end
    check("cont_go_low_cycles", low, GAP + 3);
    wait_ack(60, id, cyc);
    check("cont_second_id", id, 2);
    check("cont_second_z", int'(res_z), 1);
    req = '0;
    wait_idle(20);

    // Fairness: all requesters held for eight jobs
    do_reset();
    set_ops(0, 4'd2, 4'd2, 4'd5);
    set_ops(1, 4'd3, 4'd2, 4'd5);
    set_ops(2, 4'd4, 4'd2, 4'd5);
    set_ops(3, 4'd2, 4'd3, 4'd5);
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      wait_ack(60, id, cyc);
      check($sformatf("fair_order%0d", j), id, j % 4);
      check($sformatf("fair_z%0d", j), int'(res_z),
            int'(modexp(x_in[(j%4)*4 +: 4], e_in[(j%4)*4 +: 4], m_in[(j%4)*4 +: 4])));
    end
    req = '0;
    wait_idle(20);

    // Stale done in IDLE, then in GAP and IDLE after a job
    stale_ack = 0;
    force_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack != '0 || busy) stale_ack = 1;
    end
    force_done = 1'b0;
    check("stale_idle_quiet", int'(stale_ack), 0);
    set_ops(1, 4'd6, 4'd3, 4'd15);
    req = 4'b0010;
    wait_ack(60, id, cyc);
    check("stale_job_id", id, 1);
    req = '0;
    force_done = 1'b1;
    stale_ack = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ack != '0) stale_ack = 1;
    end
    check("stale_gap_no_ack", int'(stale_ack), 0);
    check("stale_gap_idle", int'(busy), 0);
    force_done = 1'b0;
    tick();

    // req dropped mid-RUN still completes with exactly one ack
    set_ops(1, 4'd6, 4'd3, 4'd15);
    req = 4'b0010;
    for (int k = 0; k < 10; k++) tick();
    check("drop_in_run", int'(eng_go), 1);
    req = '0;
    wait_ack(60, id, cyc);
    check("drop_ack_id", id, 1);
    check("drop_res_z", int'(res_z), 6);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ack != '0) extra++;
    end
    check("drop_single_ack", extra, 0);

    // Reset mid-RUN, then a pending requester 3 is served
    set_ops(2, 4'd5, 4'd2, 4'd7);
    req = 4'b0100;
    for (int k = 0; k < 10; k++) tick();
    check("mrst_in_run", int'(eng_go), 1);
    rst_n = 1'b0;
    tick();
    check("mrst_eng_go", int'(eng_go), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_res_z", int'(res_z), 0);
    check("mrst_res_id", int'(res_id), 0);
    check("mrst_ack", int'(ack), 0);
    rst_n = 1'b1;
    set_ops(3, 4'd3, 4'd3, 4'd13);
    req = 4'b1000;
    wait_ack(60, id, cyc);
    check("mrst_next_id", id, 3);
    check("mrst_next_z", int'(res_z), 1);
    req = '0;
    wait_idle(20);

`ifdef RSA_ARB_WATCHDOG_EN
    // Engine never finishes: abort 65 cycles after go with error and zero result
    never_done = 1'b1;
    set_ops(0, 4'd3, 4'd5, 4'd13);
    req = 4'b0001;
    cyc = 0;
    while (!eng_go && cyc < 10) begin
      tick();
      cyc++;
    end
    check("wd_go_seen", int'(eng_go), 1);
    wait_ack(200, id, cyc);
    check("wd_ack_id", id, 0);
    check("wd_ack_lat", cyc, 65);
    check("wd_res_err", int'(res_err), 1);
    check("wd_res_z", int'(res_z), 0);
    req = '0;
    never_done = 1'b0;
    wait_idle(20);
    req = 4'b0001;
    wait_ack(60, id, cyc);
    check("wd_recover_err", int'(res_err), 0);
    check("wd_recover_z", int'(res_z), 9);
    req = '0;
    wait_idle(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
